// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-dump playback sequencer:
// FSM state encoding, dump-word field positions and delta timing limits.
package regdump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH0,
        ST_FETCH1,
        ST_WAIT,
        ST_ISSUE,
        ST_DONE
    } state_t;

    localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;
    localparam logic [31:0] MIN_DELTA  = 32'd4;

    // W0 is only known one cycle after the reference cycle, so the timer is
    // primed here and topped up with (delta - MIN_DELTA) once W0 arrives.
    localparam logic [31:0] TIMER_PRIME = MIN_DELTA - 32'd2;

    localparam int W1_IDX_LSB = 0;
    localparam int W1_RD_BIT  = 7;
    localparam int W1_VAL_LSB = 8;
    localparam int W1_VAL_W   = 8;
    localparam int W1_CHK_BIT = 16;

    function automatic logic [31:0] clamp_delta(input logic [31:0] delta);
        return (delta < MIN_DELTA) ? MIN_DELTA : delta;
    endfunction

endpackage

// File: rtl/regdump_sequencer_if.sv
// Target-bus bundle of the sequencer: address/data strobes out, ready and
// read data back in.
interface regdump_sequencer_if;
    logic        RDY;
    logic [15:0] A;
    logic        RnW;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [7:0]  D_in;

    modport master (input RDY, D_in, output A, RnW, D_out, D_oe);
    modport slave  (output RDY, D_in, input A, RnW, D_out, D_oe);
endinterface

// File: rtl/regdump_delta_timer.sv
// 32-bit down counter for inter-op spacing: load has priority, otherwise it
// decrements when enabled and sticks at zero.
module regdump_delta_timer (
    input  logic        clk,
    input  logic        srst,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        dec_i,
    output logic [31:0] count_o,
    output logic        zero_o
);
    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 32'd0)) begin
            count_d = count_q - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == 32'd0);
endmodule

// File: rtl/regdump_sequencer.sv
// Replays a captured register dump onto the target bus: each two-word entry
// holds a PHI0 delay and one read or write op, with optional read checking.
module regdump_sequencer
    import regdump_pkg::*;
#(
    parameter int          MEM_AW    = 15,
    parameter logic [15:0] BASE_ADDR = 16'h4000,
    parameter int          IDX_W     = 5
) (
    input  logic              PHI0,
    input  logic              RES,
    input  logic              start,
    input  logic              loop_en,
    input  logic              RDY,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    output logic [15:0]       A,
    output logic              RnW,
    output logic [7:0]        D_out,
    output logic              D_oe,
    input  logic [7:0]        D_in,
    output logic              busy,
    output logic              done,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    output logic [15:0]       mismatch_cnt
);
    state_t            state_q, state_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rd_q, rd_d;
    logic              chk_q, chk_d;
    logic [7:0]        val_q, val_d;
    logic              rd_valid_q, rd_valid_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [15:0]       mis_q, mis_d;

    logic              tmr_load;
    logic [31:0]       tmr_val;
    logic              tmr_dec;
    logic [31:0]       tmr_count;
    logic              tmr_zero;
    logic [31:0]       tmr_after_dec;

    logic [MEM_AW:0]   next_ptr_w;
    logic              ptr_wrap;
    logic              issue;
    logic [15:0]       idx_ext;

    regdump_delta_timer u_timer (
        .clk        (PHI0),
        .srst       (RES),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .count_o    (tmr_count),
        .zero_o     (tmr_zero)
    );

    assign next_ptr_w    = {1'b0, ptr_q} + (MEM_AW+1)'(2);
    assign ptr_wrap      = next_ptr_w[MEM_AW];
    assign tmr_after_dec = (RDY && !tmr_zero) ? (tmr_count - 32'd1) : tmr_count;
    assign issue         = (state_q == ST_ISSUE);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        rd_d      = rd_q;
        chk_d     = chk_q;
        val_d     = val_q;
        tmr_load  = 1'b0;
        tmr_val   = TIMER_PRIME;
        tmr_dec   = 1'b0;
        mem_addr  = '0;
        mis_d     = mis_q;

        // mem_addr names the word needed in the following cycle.
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_FETCH0;
                    ptr_d    = '0;
                    tmr_load = 1'b1;
                    mis_d    = '0;
                end
            end
            ST_FETCH0: begin
                tmr_dec = RDY;
                if (mem_data == END_MARKER) begin
                    ptr_d = '0;
                    if (!loop_en) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    mem_addr = ptr_q + MEM_AW'(1);
                    state_d  = ST_FETCH1;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_after_dec + (clamp_delta(mem_data) - MIN_DELTA);
                end
            end
            ST_FETCH1: begin
                tmr_dec  = RDY;
                mem_addr = next_ptr_w[MEM_AW-1:0];
                idx_d    = mem_data[W1_IDX_LSB +: IDX_W];
                rd_d     = mem_data[W1_RD_BIT];
                chk_d    = mem_data[W1_CHK_BIT];
                val_d    = mem_data[W1_VAL_LSB +: W1_VAL_W];
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                tmr_dec  = RDY;
                mem_addr = next_ptr_w[MEM_AW-1:0];
                if (tmr_zero && RDY) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_addr = next_ptr_w[MEM_AW-1:0];
                tmr_load = 1'b1;
                if (rd_q && chk_q && (D_in != val_q) && (mis_q != 16'hFFFF)) begin
                    mis_d = mis_q + 16'd1;
                end
                // Running off the end of memory behaves like an end marker.
                if (ptr_wrap) begin
                    ptr_d   = '0;
                    state_d = loop_en ? ST_FETCH0 : ST_DONE;
                end else begin
                    ptr_d   = next_ptr_w[MEM_AW-1:0];
                    state_d = ST_FETCH0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rd_valid_d = issue && rd_q;
    assign rd_data_d  = (issue && rd_q) ? D_in : rd_data_q;

    always_ff @(posedge PHI0) begin
        if (RES) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            rd_q       <= 1'b0;
            chk_q      <= 1'b0;
            val_q      <= 8'h00;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
            mis_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            rd_q       <= rd_d;
            chk_q      <= chk_d;
            val_q      <= val_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            mis_q      <= mis_d;
        end
    end

    always_comb begin
        idx_ext             = 16'h0000;
        idx_ext[IDX_W-1:0]  = idx_q;
    end

    assign A            = issue ? (BASE_ADDR | idx_ext) : 16'h0000;
    assign RnW          = issue ? rd_q : 1'b1;
    assign D_oe         = issue && !rd_q;
    assign D_out        = issue ? val_q : 8'h00;
    assign busy         = (state_q == ST_FETCH0) || (state_q == ST_FETCH1) ||
                          (state_q == ST_WAIT)   || (state_q == ST_ISSUE);
    assign done         = (state_q == ST_DONE);
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign mismatch_cnt = mis_q;
endmodule

// File: tb/tb_regdump_sequencer.sv
// Directed bench for regdump_sequencer: timing, clamp, reads, RDY stalls,
// looping, wrap and reset-during-ISSUE, checked against hand-derived values.
module tb_regdump_sequencer;

    logic        PHI0 = 1'b0;
    logic        RES;
    logic        start;
    logic        loop_en;
    logic [14:0] mem_addr;
    logic [31:0] mem_data;
    logic        busy, done, rd_valid;
    logic [7:0]  rd_data;
    logic [15:0] mismatch_cnt;

    regdump_sequencer_if bus();

    // small-memory instance for the address-wrap case
    logic        start2;
    logic        loop_en2 = 1'b0;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_data2;
    logic [15:0] A2;
    logic        RnW2, D_oe2, busy2, done2, rd_valid2;
    logic [7:0]  D_out2, rd_data2;
    logic [7:0]  D_in2 = 8'h00;
    logic [15:0] mism2;

    logic [31:0] mem  [0:32767];
    logic [31:0] mem2 [0:3];

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;

    int          iss_cyc[$];
    logic [15:0] iss_a[$];
    logic        iss_rnw[$];
    logic        iss_oe[$];
    logic [7:0]  iss_dout[$];
    int          rdv_cyc[$];
    int          iss2_cyc[$];
    logic [15:0] iss2_a[$];
    logic [7:0]  iss2_dout[$];

    regdump_sequencer dut (
        .PHI0         (PHI0),
        .RES          (RES),
        .start        (start),
        .loop_en      (loop_en),
        .RDY          (bus.RDY),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .A            (bus.A),
        .RnW          (bus.RnW),
        .D_out        (bus.D_out),
        .D_oe         (bus.D_oe),
        .D_in         (bus.D_in),
        .busy         (busy),
        .done         (done),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .mismatch_cnt (mismatch_cnt)
    );

    regdump_sequencer #(.MEM_AW(2), .BASE_ADDR(16'h4000), .IDX_W(3)) dut_small (
        .PHI0         (PHI0),
        .RES          (RES),
        .start        (start2),
        .loop_en      (loop_en2),
        .RDY          (bus.RDY),
        .mem_addr     (mem_addr2),
        .mem_data     (mem_data2),
        .A            (A2),
        .RnW          (RnW2),
        .D_out        (D_out2),
        .D_oe         (D_oe2),
        .D_in         (D_in2),
        .busy         (busy2),
        .done         (done2),
        .rd_valid     (rd_valid2),
        .rd_data      (rd_data2),
        .mismatch_cnt (mism2)
    );

    always #5 PHI0 = ~PHI0;

    always @(posedge PHI0) begin
        cyc       <= cyc + 1;
        mem_data  <= mem[mem_addr];
        mem_data2 <= mem2[mem_addr2];
    end

    // one line per bus transaction
    always @(negedge PHI0) begin
        if (bus.A != 16'h0000) begin
            iss_cyc.push_back(cyc);
            iss_a.push_back(bus.A);
            iss_rnw.push_back(bus.RnW);
            iss_oe.push_back(bus.D_oe);
            iss_dout.push_back(bus.D_out);
            $display("op  cyc=%0d A=%h RnW=%b D_oe=%b D_out=%h D_in=%h",
                     cyc, bus.A, bus.RnW, bus.D_oe, bus.D_out, bus.D_in);
        end
        if (rd_valid) rdv_cyc.push_back(cyc);
        if (A2 != 16'h0000) begin
            iss2_cyc.push_back(cyc);
            iss2_a.push_back(A2);
            iss2_dout.push_back(D_out2);
            $display("op2 cyc=%0d A=%h RnW=%b D_out=%h", cyc, A2, RnW2, D_out2);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge PHI0);
        #1;
    endtask

    function automatic logic [31:0] mk_w1(input logic chk, input logic [7:0] val,
                                          input logic rd, input logic [6:0] idx);
        return {15'b0, chk, val, rd, idx};
    endfunction

    task automatic clear_all();
        for (int i = 0; i < 16; i++) mem[i] = 32'hFFFF_FFFF;
        iss_cyc.delete(); iss_a.delete(); iss_rnw.delete();
        iss_oe.delete(); iss_dout.delete(); rdv_cyc.delete();
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_issues(input string tag, input int n, input int budget);
        int k = 0;
        while (iss_cyc.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'(iss_cyc.size()), 32'(n));
    endtask

    initial begin
        int s;
        int t;
        RES = 1'b1; start = 1'b0; loop_en = 1'b0; start2 = 1'b0;
        bus.RDY = 1'b1; bus.D_in = 8'h00;
        for (int i = 0; i < 4; i++) mem2[i] = 32'hFFFF_FFFF;
        clear_all();
        tick(3);

        // reset state
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_A", 32'(bus.A), 32'h0);
        check("rst_RnW", 32'(bus.RnW), 32'h1);
        check("rst_D_oe", 32'(bus.D_oe), 32'h0);
        check("rst_D_out", 32'(bus.D_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_mismatch", 32'(mismatch_cnt), 32'h0);
        RES = 1'b0;
        tick(2);

        // single write, delta 10
        clear_all();
        mem[0] = 32'd10; mem[1] = mk_w1(1'b0, 8'hA5, 1'b0, 7'd3);
        tick(1);
        pulse_start(s);
        check("t1_busy", 32'(busy), 32'h1);
        wait_issues("t1_count", 1, 40);
        check("t1_cyc", 32'(iss_cyc[0]), 32'(s + 10));
        check("t1_A", 32'(iss_a[0]), 32'h4003);
        check("t1_RnW", 32'(iss_rnw[0]), 32'h0);
        check("t1_D_oe", 32'(iss_oe[0]), 32'h1);
        check("t1_D_out", 32'(iss_dout[0]), 32'hA5);
        tick(4);
        check("t1_done", 32'(done), 32'h1);
        check("t1_busy_end", 32'(busy), 32'h0);
        check("t1_ops", 32'(iss_cyc.size()), 32'h1);

        // MIN_DELTA clamp, restart from DONE
        clear_all();
        mem[0] = 32'd1; mem[1] = mk_w1(1'b0, 8'h01, 1'b0, 7'd0);
        mem[2] = 32'd0; mem[3] = mk_w1(1'b0, 8'h02, 1'b0, 7'd1);
        tick(1);
        pulse_start(s);
        check("t2_done_clr", 32'(done), 32'h0);
        wait_issues("t2_count", 2, 40);
        check("t2_cyc0", 32'(iss_cyc[0]), 32'(s + 4));
        check("t2_gap", 32'(iss_cyc[1] - iss_cyc[0]), 32'd4);
        check("t2_A1", 32'(iss_a[1]), 32'h4001);
        tick(4);

        // checked read with mismatch
        clear_all();
        mem[0] = 32'd6; mem[1] = mk_w1(1'b1, 8'h12, 1'b1, 7'd5);
        bus.D_in = 8'h34;
        tick(1);
        pulse_start(s);
        wait_issues("t3_count", 1, 40);
        check("t3_cyc", 32'(iss_cyc[0]), 32'(s + 6));
        check("t3_A", 32'(iss_a[0]), 32'h4005);
        check("t3_RnW", 32'(iss_rnw[0]), 32'h1);
        check("t3_D_oe", 32'(iss_oe[0]), 32'h0);
        check("t3_D_out", 32'(iss_dout[0]), 32'h12);
        tick(3);
        check("t3_rd_data", 32'(rd_data), 32'h34);
        check("t3_rdv_count", 32'(rdv_cyc.size()), 32'h1);
        check("t3_rdv_cyc", 32'(rdv_cyc[0]), 32'(iss_cyc[0] + 1));
        check("t3_mismatch", 32'(mismatch_cnt), 32'h1);
        tick(2);

        // RDY stall of 7 cycles in WAIT, plus a start pulse while busy
        clear_all();
        mem[0] = 32'd20; mem[1] = mk_w1(1'b0, 8'h5A, 1'b0, 7'd2);
        tick(1);
        pulse_start(s);
        check("t4_mis_clr", 32'(mismatch_cnt), 32'h0);
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        bus.RDY = 1'b0;
        tick(7);
        bus.RDY = 1'b1;
        wait_issues("t4_count", 1, 60);
        check("t4_cyc", 32'(iss_cyc[0]), 32'(s + 27));
        tick(6);
        check("t4_ops", 32'(iss_cyc.size()), 32'h1);

        // looping two-entry dump, then drop loop_en
        clear_all();
        mem[0] = 32'd8; mem[1] = mk_w1(1'b0, 8'h11, 1'b0, 7'd1);
        mem[2] = 32'd8; mem[3] = mk_w1(1'b0, 8'h22, 1'b0, 7'd2);
        loop_en = 1'b1;
        tick(1);
        pulse_start(s);
        wait_issues("t5_count", 6, 100);
        loop_en = 1'b0;
        check("t5_done_loop", 32'(done), 32'h0);
        for (int i = 0; i < 6; i++) begin
            check("t5_cyc", 32'(iss_cyc[i]), 32'(s + 8 * (i + 1)));
            check("t5_A", 32'(iss_a[i]), (i % 2 == 0) ? 32'h4001 : 32'h4002);
        end
        tick(3);
        check("t5_done", 32'(done), 32'h1);
        check("t5_ops", 32'(iss_cyc.size()), 32'h6);

        // reset during a read ISSUE
        clear_all();
        mem[0] = 32'd5; mem[1] = mk_w1(1'b1, 8'h00, 1'b1, 7'd7);
        bus.D_in = 8'h99;
        tick(1);
        pulse_start(s);
        wait_issues("t6_count", 1, 40);
        t = iss_cyc[0];
        check("t6_cyc", 32'(t), 32'(s + 5));
        RES = 1'b1;
        tick(1);
        check("t6_A", 32'(bus.A), 32'h0);
        check("t6_RnW", 32'(bus.RnW), 32'h1);
        check("t6_D_oe", 32'(bus.D_oe), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_rd_data", 32'(rd_data), 32'h0);
        check("t6_rd_valid", 32'(rd_valid), 32'h0);
        check("t6_mismatch", 32'(mismatch_cnt), 32'h0);
        RES = 1'b0;
        tick(3);
        check("t6_no_rdv", 32'(rdv_cyc.size()), 32'h0);
        check("t6_idle", 32'(busy), 32'h0);

        // word-address wrap on a 4-word memory, idx upper bits ignored
        mem2[0] = 32'd6; mem2[1] = mk_w1(1'b0, 8'h11, 1'b0, 7'd1);
        mem2[2] = 32'd6; mem2[3] = mk_w1(1'b0, 8'h22, 1'b0, 7'h7A);
        tick(1);
        start2 = 1'b1;
        s = cyc;
        tick(1);
        start2 = 1'b0;
        for (int k = 0; k < 40 && iss2_cyc.size() < 2; k++) tick(1);
        check("t7_count", 32'(iss2_cyc.size()), 32'h2);
        check("t7_cyc0", 32'(iss2_cyc[0]), 32'(s + 6));
        check("t7_cyc1", 32'(iss2_cyc[1]), 32'(s + 12));
        check("t7_A1", 32'(iss2_a[1]), 32'h4002);
        check("t7_D_out1", 32'(iss2_dout[1]), 32'h22);
        tick(4);
        check("t7_done", 32'(done2), 32'h1);
        check("t7_ops", 32'(iss2_cyc.size()), 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regdump_sequencer.md
REGDUMP_SEQUENCER -- requirements
Module: regdump_sequencer

Interface
REQ-001 Parameter MEM_AW, default 15: register-dump memory word-address width.
REQ-002 Parameter BASE_ADDR, default 16'h4000: register block base address.
REQ-003 Parameter IDX_W, default 5, range 1..7: register index width.
REQ-004 Ports SHALL be, clock and reset first:
 PHI0  in  1  core clock; the only clock.
 RES  in  1  reset; synchronous, active-high.
 start  in  1  begin playback from word 0; honoured only in IDLE or DONE.
 loop_en  in  1  on end marker, restart at word 0 instead of stopping.
 RDY  in  1  0: freeze delta counter and hold any pending bus op.
 mem_addr  out  MEM_AW  dump memory word address.
 mem_data  in  32  dump word; synchronous memory, valid 1 cycle after mem_addr.
 A  out  16  address bus.
 RnW  out  1  1: read, 0: write.
 D_out  out  8  write data.
 D_oe  out  1  drive D_out onto the data bus.
 D_in  in  8  read data, sampled at end of the read cycle.
 busy  out  1  playback active.
 done  out  1  end reached with loop_en=0.
 rd_valid  out  1  one-cycle pulse; rd_data valid.
 rd_data  out  8  last captured read value.
 mismatch_cnt  out  16  checked reads whose value differed, saturating.

Function
REQ-005 Entry = two 32-bit words: W0 = phiDelta; W1 = {15'b0, chk[16], value[15:8], rd[7], 7'b(idx, upper bits ignored above IDX_W)}.
REQ-006 W0 == 32'hFFFF_FFFF SHALL be the end marker; W1 of that entry is not fetched.
REQ-007 States: IDLE, FETCH0, FETCH1, WAIT, ISSUE, DONE.
REQ-008 IDLE --start--> FETCH0 (mem_addr=0); FETCH0 -> FETCH1 latches W0; FETCH1 -> WAIT latches W1; WAIT -> ISSUE when delta counter reaches 0 and RDY=1; ISSUE -> FETCH0 of next entry.
REQ-009 Delta timing: the op of entry n SHALL issue exactly max(phiDelta_n, 4) PHI0 cycles after the ISSUE cycle of entry n-1; entry 0 measured from the cycle start is sampled high.
REQ-010 Delta counter SHALL be 32 bits, loaded at the reference cycle, decremented each cycle with RDY=1, held with RDY=0, never wraps below 0.
REQ-011 Cycles with RDY=0 SHALL extend the interval one-for-one.
REQ-012 ISSUE lasts exactly one cycle: A = BASE_ADDR | idx (zero-extended), RnW = rd, D_oe = ~rd, D_out = value.
REQ-013 Outside ISSUE: A = 16'h0000, RnW = 1, D_oe = 0, D_out = 0.
REQ-014 Read ISSUE: D_in captured into rd_data at the clock edge ending the cycle; rd_valid high the following cycle for one cycle.
REQ-015 If rd=1 and chk=1 and D_in != value, mismatch_cnt increments by 1, saturating at 16'hFFFF.
REQ-016 End marker with loop_en=0: enter DONE, busy=0, done=1 until start or RES.
REQ-017 End marker with loop_en=1: return to FETCH0 at word 0; the next op is timed against the last ISSUE per REQ-009; mismatch_cnt is not cleared.
REQ-018 Word-address wrap: if the next fetch address would exceed 2^MEM_AW-1, treat it as an end marker.
REQ-019 start in DONE SHALL clear done and mismatch_cnt and restart at word 0.
REQ-020 start while busy SHALL be ignored.
REQ-021 busy = 1 in FETCH0..ISSUE.

Reset
REQ-022 RES=1 at a clock edge SHALL force IDLE from any state, including mid-ISSUE; an in-flight read is not captured.
REQ-023 Reset values: mem_addr 0, A 0, RnW 1, D_oe 0, D_out 0, busy 0, done 0, rd_valid 0, rd_data 0, mismatch_cnt 0, delta counter 0.

Structure
REQ-024 Shared package regdump_pkg SHALL hold the state enum, END_MARKER = 32'hFFFF_FFFF, MIN_DELTA = 4, and W1 field bit positions.
REQ-025 One sub-module, regdump_delta_timer, SHALL contain the 32-bit load/hold/decrement counter with a zero flag.

Verification
REQ-026 Entry (10, write idx 3 value 8'hA5), then end marker -> ISSUE 10 cycles after start with A=16'h4003, RnW=0, D_oe=1, D_out=8'hA5; done=1 afterwards.
REQ-027 Entry (1, write), then entry (0, write) -> ops spaced at 4 cycles (MIN_DELTA clamp).
REQ-028 Read idx 5, chk=1, value 8'h12, bench drives D_in=8'h34 -> rd_data=8'h34, one rd_valid pulse, mismatch_cnt=1.
REQ-029 Delta 20 with RDY held low for 7 cycles in WAIT -> ISSUE at cycle 27.
REQ-030 loop_en=1, two-entry dump -> ops repeat indefinitely, done stays 0; dropping loop_en -> DONE at the next end marker.
REQ-031 RES asserted during a read ISSUE -> next cycle IDLE, all outputs at reset values, no rd_valid pulse.
